// File: rtl/mult_div_pkg.sv
// Op encodings and FSM states shared by the multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mult_div_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Two's-complement negation of a HI/LO pair, either as one 2W value or per half.
// Latency: combinational.
// Backpressure: not applicable.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic         i_neg_pair,
    input  logic         i_neg_hi,
    input  logic         i_neg_lo,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);
    logic [2*W-1:0] w_pair_neg;

    assign w_pair_neg = -{i_hi, i_lo};

    always_comb begin
        o_hi = i_neg_hi ? -i_hi : i_hi;
        o_lo = i_neg_lo ? -i_lo : i_lo;
        // Full-width negation wins: a signed product carries across the halves.
        if (i_neg_pair) begin
            {o_hi, o_lo} = w_pair_neg;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU producing HI/LO, one bit per cycle.
// Latency: WIDTH+1 cycles from Start to Done; divide-by-zero finishes in 1.
// Backpressure: Start is only accepted in IDLE; Start while Busy or Done is dropped.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out
);
    state_e             r_state, w_nstate;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div, r_neg_q, r_neg_r, r_div_zero;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_is_div, w_signed, w_b_zero, w_last, w_qbit;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]     w_mul_sum, w_div_rs, w_div_diff;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_acc_next;

    assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_b_zero = (i_src_b == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    mdu_sign_fix #(.W(WIDTH)) u_operand_fix (
        .i_hi       (i_src_a),
        .i_lo       (i_src_b),
        .i_neg_pair (1'b0),
        .i_neg_hi   (w_signed & i_src_a[WIDTH-1]),
        .i_neg_lo   (w_signed & i_src_b[WIDTH-1]),
        .o_hi       (w_a_mag),
        .o_lo       (w_b_mag)
    );

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend}; shift left, restore if the trial subtract borrows.
    assign w_div_rs   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_rs - {1'b0, r_opnd};
    assign w_qbit     = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_qbit ? w_div_diff[WIDTH-1:0] : w_div_rs[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_qbit};
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    mdu_sign_fix #(.W(WIDTH)) u_result_fix (
        .i_hi       (w_acc_next[2*WIDTH-1:WIDTH]),
        .i_lo       (w_acc_next[WIDTH-1:0]),
        .i_neg_pair (~r_is_div & r_neg_q),
        .i_neg_hi   (r_is_div & r_neg_r),
        .i_neg_lo   (r_is_div & r_neg_q),
        .o_hi       (w_fix_hi),
        .o_lo       (w_fix_lo)
    );

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_nstate = (w_is_div && w_b_zero) ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_nstate = S_DONE;
            S_DONE: w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_nstate;
            if (r_state == S_IDLE && i_start) begin
                r_cnt    <= '0;
                r_is_div <= w_is_div;
                r_neg_q  <= w_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
                r_neg_r  <= w_signed & i_src_a[WIDTH-1];
                r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                if (w_is_div && w_b_zero) begin
                    r_div_zero <= 1'b1;
                    r_hi       <= '0;
                    r_lo       <= '0;
                end
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cnt      <= '0;
                    r_div_zero <= 1'b0;
                    r_hi       <= w_fix_hi;
                    r_lo       <= w_fix_lo;
                end
            end
        end
    end

    assign o_busy     = (r_state == S_CALC);
    assign o_done     = (r_state == S_DONE);
    assign o_div_zero = r_div_zero;
    assign o_hi_out   = r_hi;
    assign o_lo_out   = r_lo;
endmodule
